// File: rtl/stack_controller.sv
// ---------------------------------------------------------------------------
// stack_controller
//   Drives the push/pop strobes of the 8Queen stack datapath from a single-
//   request handshake issued by the solver FSM. It blocks illegal operations
//   and reports each one as a one-cycle error pulse. It also marks the cycle
//   in which the datapath's bus_out holds the popped top-of-stack.
//
//   Configuration macro: STACK_CTRL_CLEAR_EN
//     When defined, this adds the clear_req port and the DRAIN state. DRAIN
//     pops the stack down to empty. When undefined, neither exists.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   push_req       in   one push request, sampled only while ready=1
//   pop_req        in   one pop request, sampled only while ready=1
//   clear_req      in   drain stack to empty (STACK_CTRL_CLEAR_EN only)
//   msb            in   datapath full flag  (count == DEPTH)
//   zero           in   datapath empty flag (count == 0)
//   push           out  datapath push strobe
//   pop            out  datapath pop strobe
//   ready          out  idle, a request is accepted this cycle
//   data_valid     out  bus_out holds the popped entry this cycle
//   done           out  one-cycle pulse, operation complete
//   overflow_err   out  one-cycle pulse, push requested while full
//   underflow_err  out  one-cycle pulse, pop requested while empty
//   req_err        out  one-cycle pulse, push_req and pop_req together
//   full / empty   out  combinational copies of msb / zero
// ---------------------------------------------------------------------------
module stack_controller #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push_req,
    input  logic pop_req,
`ifdef STACK_CTRL_CLEAR_EN
    input  logic clear_req,
`endif
    input  logic msb,
    input  logic zero,
    output logic push,
    output logic pop,
    output logic ready,
    output logic data_valid,
    output logic done,
    output logic overflow_err,
    output logic underflow_err,
    output logic req_err,
    output logic full,
    output logic empty
);

    // DEPTH only has to agree with the datapath; it shapes no logic here.
    if (DEPTH < 1) begin : g_bad_depth
        $error("stack_controller: DEPTH must be at least 1");
    end

`ifdef STACK_CTRL_CLEAR_EN
    typedef enum logic [2:0] {IDLE, PUSH, POP, DONE, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, PUSH, POP, DONE} state_t;
`endif

    state_t state_q, state_d;
    logic   done_q, done_d;
    logic   ovf_q, ovf_d;
    logic   unf_q, unf_d;
    logic   req_q, req_d;

    always_comb begin
        state_d = state_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        req_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
`ifdef STACK_CTRL_CLEAR_EN
                // A clear overrides any push/pop request in the same cycle.
                if (clear_req)
                    state_d = zero ? DONE : DRAIN;
                else
`endif
                if (push_req && pop_req)
                    req_d = 1'b1;
                else if (push_req && msb)
                    ovf_d = 1'b1;
                else if (push_req)
                    state_d = PUSH;
                else if (pop_req && zero)
                    unf_d = 1'b1;
                else if (pop_req)
                    state_d = POP;
            end
            PUSH:  state_d = DONE;
            POP:   state_d = DONE;
            DONE:  state_d = IDLE;
`ifdef STACK_CTRL_CLEAR_EN
            DRAIN: if (zero) state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            req_q   <= req_d;
        end
    end

    assign ready         = (state_q == IDLE);
    assign push          = (state_q == PUSH);
    assign data_valid    = (state_q == POP);
`ifdef STACK_CTRL_CLEAR_EN
    // The drain pop is gated by zero. This keeps the extra DRAIN cycle, which
    // spends its time waiting for the empty flag, from popping an empty stack.
    assign pop           = (state_q == POP) || ((state_q == DRAIN) && !zero);
`else
    assign pop           = (state_q == POP);
`endif
    assign done          = done_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign req_err       = req_q;
    assign full          = msb;
    assign empty         = zero;

    // The datapath can never be full and empty at once.
    a_flags_exclusive: assert property (@(posedge clk) disable iff (reset) !(msb && zero));

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller. It includes a small behavioural model
// of the 8-entry stack datapath that feeds msb/zero and provides bus_out.
module tb_stack_controller;

    logic clk = 1'b0;
    logic reset, push_req, pop_req, clear_req;
    logic msb, zero;
    logic push, pop, ready, data_valid, done;
    logic overflow_err, underflow_err, req_err, full, empty;

    int errors = 0;
    int checks = 0;

    // Datapath model.
    logic [7:0] mem [8];
    int         count;
    logic [7:0] bus_in, bus_out;

    always #5 clk = ~clk;

    assign msb     = (count == 8);
    assign zero    = (count == 0);
    assign bus_out = (count > 0) ? mem[count-1] : 8'h00;

    always @(posedge clk) begin
        if (reset) count <= 0;
        else if (push && count < 8) begin
            mem[count] <= bus_in;
            count      <= count + 1;
        end else if (pop && count > 0) count <= count - 1;
    end

    stack_controller #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
`ifdef STACK_CTRL_CLEAR_EN
        .clear_req(clear_req),
`endif
        .msb(msb), .zero(zero), .push(push), .pop(pop), .ready(ready),
        .data_valid(data_valid), .done(done), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .req_err(req_err), .full(full), .empty(empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 10) begin step(); n++; end
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL wait_ready: got ready=0 expected 1 within 10 cycles");
        end
    endtask

    task automatic do_push(input logic [7:0] v);
        wait_ready();
        bus_in = v; push_req = 1'b1;
        step();
        push_req = 1'b0;
        chk("push_strobe", push, 1);
        chk("push_no_done", done, 0);
        step();
        chk("push_strobe_end", push, 0);
        chk("push_done", done, 1);
        step();
        chk("push_done_end", done, 0);
        chk("push_ready", ready, 1);
    endtask

    task automatic do_pop(input logic [7:0] exp);
        wait_ready();
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        chk("pop_strobe", pop, 1);
        chk("pop_data_valid", data_valid, 1);
        chk("pop_data", bus_out, exp);
        step();
        chk("pop_strobe_end", pop, 0);
        chk("pop_done", done, 1);
        step();
        chk("pop_ready", ready, 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_ready", ready, 1);
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_done", done, 0);
        chk("rst_empty", empty, 1);
    endtask

    task automatic test_push_pop();
        do_push(8'h15);
        do_push(8'h2A);
        chk("pp_count", count, 2);
        do_pop(8'h2A);
        do_pop(8'h15);
        chk("pp_empty", empty, 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) do_push(8'(8'h40 + i));
        chk("ovf_full", full, 1);
        push_req = 1'b1; bus_in = 8'hEE;
        step();
        push_req = 1'b0;
        chk("ovf_pulse", overflow_err, 1);
        chk("ovf_no_push", push, 0);
        chk("ovf_ready", ready, 1);
        step();
        chk("ovf_pulse_end", overflow_err, 0);
        chk("ovf_count", count, 8);
        for (int i = 7; i >= 0; i--) do_pop(8'(8'h40 + i));
        chk("ovf_drained", empty, 1);
    endtask

    task automatic test_errors();
        wait_ready();
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        chk("unf_pulse", underflow_err, 1);
        chk("unf_no_pop", pop, 0);
        step();
        chk("unf_pulse_end", underflow_err, 0);
        push_req = 1'b1; pop_req = 1'b1;
        step();
        push_req = 1'b0; pop_req = 1'b0;
        chk("req_pulse", req_err, 1);
        chk("req_no_push", push, 0);
        chk("req_no_pop", pop, 0);
        chk("req_no_ovf", overflow_err, 0);
        step();
        chk("req_pulse_end", req_err, 0);
        chk("req_count", count, 0);
    endtask

    task automatic test_reset_mid_pop();
        do_push(8'h33);
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        chk("rmp_in_pop", pop, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmp_pop_cleared", pop, 0);
        chk("rmp_ready", ready, 1);
        chk("rmp_empty", empty, 1);
        chk("rmp_done", done, 0);
        do_push(8'h44);
        do_pop(8'h44);
    endtask

    task automatic test_back_to_back();
        // Requests during the PUSH/DONE cycles must be ignored, not queued.
        wait_ready();
        bus_in = 8'h5A; push_req = 1'b1;
        step();
        chk("b2b_push", push, 1);
        step();
        chk("b2b_done", done, 1);
        chk("b2b_no_push", push, 0);
        push_req = 1'b0;
        step();
        chk("b2b_ready", ready, 1);
        chk("b2b_count", count, 1);
        do_pop(8'h5A);
    endtask

`ifdef STACK_CTRL_CLEAR_EN
    task automatic test_clear();
        int pops = 0;
        int n    = 0;
        bit seen = 0;
        for (int i = 0; i < 5; i++) do_push(8'(i + 1));
        wait_ready();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        while (!done && n < 20) begin
            if (pop) pops++;
            chk("clr_no_dv", data_valid, 0);
            step(); n++;
        end
        seen = done;
        chk("clr_done_seen", seen, 1);
        chk("clr_pops", pops, 5);
        chk("clr_empty", empty, 1);
        chk("clr_no_unf", underflow_err, 0);
        step();
        wait_ready();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_empty_done", done, 1);
        chk("clr_empty_no_pop", pop, 0);
    endtask
`endif

    initial begin
        reset = 1'b1; push_req = 1'b0; pop_req = 1'b0; clear_req = 1'b0;
        bus_in = 8'h00;
        test_reset();
        test_push_pop();
        test_overflow();
        test_errors();
        test_reset_mid_pop();
        test_back_to_back();
`ifdef STACK_CTRL_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
